lane_serializer: RTL and testbench
==================================

// Module: lane_serializer
// PURPOSE
//   Takes one packed multi-lane word ([LANES][W]) plus a per-lane valid mask and emits the
//   enabled lanes one per cycle on a single W-bit stream, lowest lane first, tagged with the lane index.
//   It is the reverse of the per-lane-to-array gathering done at top level: the array bus
//   arrives here and leaves lane by lane toward narrow per-lane consumers.
//   Valid/ready handshake on both sides. Back-to-back words stream with no bubble.
// PARAMETERS
//   LANES   3   number of lanes in the packed input word (>=2)
//   W       8   width of one lane in bits
//   LW      $clog2(LANES)   localparam, lane index width
// PORTS
//   clk        in   1          single clock, all logic rising-edge
//   rst        in   1          asynchronous, active-high reset
//   in_data    in   [LANES-1:0][W-1:0]  packed lanes, lane 0 in bits [W-1:0]
//   in_mask    in   LANES      bit i set = lane i present
//   in_valid   in   1          input word valid
//   in_ready   out  1          block can accept a word this cycle
//   out_data   out  W          current lane payload
//   out_lane   out  LW         index of lane on out_data
//   out_last   out  1          final enabled lane of the current word
//   out_valid  out  1          out_* valid
//   out_ready  in   1          downstream accepts out_* this cycle
//   busy       out  1          a word is held (state SEND)
// BEHAVIOUR
//   - Reset (async, immediate): state=IDLE, out_valid=0, out_data=0, out_lane=0, out_last=0,
//     busy=0, hold regs cleared; in_ready=1 while in reset-released IDLE. A word in flight is discarded.
//   - Accept = in_valid & in_ready. in_ready = (state==IDLE) | (out_valid & out_ready & out_last).
//   - FSM: IDLE -> SEND on accept with in_mask!=0; SEND -> IDLE on last-beat handshake with
//     no new accept; SEND -> SEND on last-beat handshake that also accepts a nonzero-mask word.
//   - On accept: capture in_data into hold, in_mask into rem; out_valid=1 next cycle (latency 1)
//     with out_lane = lowest set bit of in_mask, out_data = hold[out_lane].
//   - in_mask==0: word accepted and dropped; no output beat; state unchanged (IDLE), or
//     goes IDLE if accepted on a last-beat handshake.
//   - Output handshake (out_valid & out_ready): clear rem[out_lane]; next cycle presents the
//     next lowest set bit of rem. out_last = (rem has exactly one bit set), registered with beat.
//   - Backpressure: while out_valid & !out_ready, out_data/out_lane/out_last held stable,
//     rem unchanged, in_ready=0.
//   - out_valid never drops without a handshake except on reset.
//   - Single-lane mask: one beat with out_last=1. Full mask: LANES beats, lanes 0..LANES-1.
//   - in_data/in_mask not sampled except on accept; changes at other times are ignored.
//   - Throughput: one beat per cycle with out_ready=1; a word with k lanes occupies k cycles.
// TESTING
//   1. LANES=3,W=8: in_data={33,22,11}h, mask=111, out_ready=1, accept at cycle N -> beats
//      (11,lane0),(22,lane1),(33,lane2,last) at N+1..N+3; in_ready=1 in N+3.
//   2. mask=101, data {33,22,11}h -> (11,lane0),(33,lane2,last); lane1 never emitted.
//   3. mask=000 with in_valid=1 -> in_ready stays 1, out_valid stays 0, busy stays 0.
//   4. mask=111, out_ready low for 2 cycles while lane1 presented -> out_data=22h, out_lane=1
//      held 2 cycles, in_ready=0; resumes with 33h last after out_ready returns.
//   5. Words A={03,02,01}h mask 111 and B={0C,0B,0A}h mask 011, in_valid held -> stream
//      01,02,03(last),0A,0B(last) on 5 consecutive cycles, no bubble.
//   6. mask=111, assert rst after lane0 handshake -> out_valid=0 before next edge; after
//      release send mask=010 data {..,55,..}h -> single beat (55,lane1,last).

Source files
------------

// File: rtl/lane_serializer.sv
// Serializes the enabled lanes of one packed multi-lane word onto a single W-bit
// stream, lowest lane first, each beat tagged with its lane index.
module lane_serializer #(
   parameter  int unsigned LANES = 3,
   parameter  int unsigned W     = 8,
   localparam int unsigned LW    = $clog2(LANES)
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [LANES-1:0][W-1:0]   in_data,
   input  logic [LANES-1:0]          in_mask,
   input  logic                      in_valid,
   output logic                      in_ready,
   output logic [W-1:0]              out_data,
   output logic [LW-1:0]             out_lane,
   output logic                      out_last,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic                      busy
);

   typedef enum logic {
      IDLE = 1'b0,
      SEND = 1'b1
   } state_t;

   state_t                    r_state;
   logic [LANES-1:0][W-1:0]   r_hold;
   logic [LANES-1:0]          r_rem;
   logic [W-1:0]              r_out_data;
   logic [LW-1:0]             r_out_lane;
   logic                      r_out_last;
   logic                      r_out_valid;

   logic                      w_hs;
   logic                      w_last_hs;
   logic                      w_in_ready;
   logic                      w_load;
   logic [LANES-1:0]          w_rem_adv;
   logic [LW-1:0]             w_in_lane;
   logic [LW-1:0]             w_adv_lane;

   // Index of the lowest set bit; zero for an empty mask.
   function automatic logic [LW-1:0] f_lowest(input logic [LANES-1:0] m);
      f_lowest = '0;
      for (int i = int'(LANES) - 1; i >= 0; i--) begin
         if (m[i]) f_lowest = LW'(i);
      end
   endfunction

   function automatic logic f_onehot(input logic [LANES-1:0] m);
      f_onehot = (m != '0) && ((m & (m - LANES'(1))) == '0);
   endfunction

   assign w_hs       = r_out_valid & out_ready;
   assign w_last_hs  = w_hs & r_out_last;
   assign w_in_ready = (r_state == IDLE) | w_last_hs;
   assign w_load     = in_valid & w_in_ready & (in_mask != '0);
   assign w_rem_adv  = r_rem & ~(LANES'(1) << r_out_lane);
   assign w_in_lane  = f_lowest(in_mask);
   assign w_adv_lane = f_lowest(w_rem_adv);

   // A nonzero-mask accept always wins; it can coincide with the last-beat handshake.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= IDLE;
         r_hold      <= '0;
         r_rem       <= '0;
         r_out_data  <= '0;
         r_out_lane  <= '0;
         r_out_last  <= 1'b0;
         r_out_valid <= 1'b0;
      end else if (w_load) begin
         r_state     <= SEND;
         r_hold      <= in_data;
         r_rem       <= in_mask;
         r_out_data  <= in_data[w_in_lane];
         r_out_lane  <= w_in_lane;
         r_out_last  <= f_onehot(in_mask);
         r_out_valid <= 1'b1;
      end else if (w_hs) begin
         if (r_out_last) begin
            r_state     <= IDLE;
            r_rem       <= '0;
            r_out_valid <= 1'b0;
         end else begin
            r_rem       <= w_rem_adv;
            r_out_data  <= r_hold[w_adv_lane];
            r_out_lane  <= w_adv_lane;
            r_out_last  <= f_onehot(w_rem_adv);
         end
      end
   end

   assign in_ready  = w_in_ready;
   assign out_data  = r_out_data;
   assign out_lane  = r_out_lane;
   assign out_last  = r_out_last;
   assign out_valid = r_out_valid;
   assign busy      = (r_state == SEND);

endmodule

// File: tb/tb_lane_serializer.sv
// Directed bench for lane_serializer (LANES=3, W=8): per-cycle vectors with
// hand-computed expected output states.
module tb_lane_serializer;

   logic              clk = 1'b0;
   logic              rst;
   logic [2:0][7:0]   in_data;
   logic [2:0]        in_mask;
   logic              in_valid;
   logic              in_ready;
   logic [7:0]        out_data;
   logic [1:0]        out_lane;
   logic              out_last;
   logic              out_valid;
   logic              out_ready;
   logic              busy;

   int n_checks = 0;
   int n_fail   = 0;

   lane_serializer #(.LANES(3), .W(8)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_data   (in_data),
      .in_mask   (in_mask),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .out_data  (out_data),
      .out_lane  (out_lane),
      .out_last  (out_last),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   // Observation word: {valid, busy, ready, last, lane[1:0], data[7:0]}.
   logic [13:0] obs;
   assign obs = {out_valid, busy, in_ready, out_last, out_lane, out_data};

   typedef struct {
      logic        iv;
      logic [23:0] d;
      logic [2:0]  m;
      logic        ordy;
      logic [13:0] e;
   } vec_t;

   function automatic logic [13:0] ex(input logic v, input logic b, input logic r,
                                      input logic l, input logic [1:0] lane,
                                      input logic [7:0] data);
      ex = {v, b, r, l, lane, data};
   endfunction

   task automatic drive(input vec_t v);
      in_valid  = v.iv;
      in_data   = v.d;
      in_mask   = v.m;
      out_ready = v.ordy;
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      in_valid = 1'b0; in_data = '0; in_mask = '0; out_ready = 1'b1;
      @(posedge clk); @(posedge clk); #1;
      n_checks++;
      if (obs !== ex(0, 0, 1, 0, 2'd0, 8'h00))
         $display("FAIL reset_state: got %h expected %h", obs, ex(0, 0, 1, 0, 2'd0, 8'h00));
      if (obs !== ex(0, 0, 1, 0, 2'd0, 8'h00)) n_fail++;
      rst = 1'b0;
      next_cycle();
   endtask

   task automatic test_full_mask();
      vec_t vs [5] = '{
         '{1'b1, 24'h332211, 3'b111, 1'b1, ex(0, 0, 1, 0, 2'd0, 8'h00)},
         '{1'b0, 24'h000000, 3'b000, 1'b1, ex(1, 1, 0, 0, 2'd0, 8'h11)},
         '{1'b0, 24'h000000, 3'b000, 1'b1, ex(1, 1, 0, 0, 2'd1, 8'h22)},
         '{1'b0, 24'h000000, 3'b000, 1'b1, ex(1, 1, 1, 1, 2'd2, 8'h33)},
         '{1'b0, 24'h000000, 3'b000, 1'b1, ex(0, 0, 1, 0, 2'd0, 8'h00)}};
      for (int i = 0; i < 5; i++) begin
         drive(vs[i]); #1;
         n_checks++;
         if (vs[i].e[13] ? (obs !== vs[i].e) : (obs[13:11] !== vs[i].e[13:11])) begin
            n_fail++;
            $display("FAIL full_mask cycle %0d: got %h expected %h", i, obs, vs[i].e);
         end
         next_cycle();
      end
   endtask

   task automatic test_sparse_mask();
      vec_t vs [4] = '{
         '{1'b1, 24'h332211, 3'b101, 1'b1, ex(0, 0, 1, 0, 2'd0, 8'h00)},
         '{1'b0, 24'h000000, 3'b000, 1'b1, ex(1, 1, 0, 0, 2'd0, 8'h11)},
         '{1'b0, 24'h000000, 3'b000, 1'b1, ex(1, 1, 1, 1, 2'd2, 8'h33)},
         '{1'b0, 24'h000000, 3'b000, 1'b1, ex(0, 0, 1, 0, 2'd0, 8'h00)}};
      for (int i = 0; i < 4; i++) begin
         drive(vs[i]); #1;
         n_checks++;
         if (vs[i].e[13] ? (obs !== vs[i].e) : (obs[13:11] !== vs[i].e[13:11])) begin
            n_fail++;
            $display("FAIL sparse_mask cycle %0d: got %h expected %h", i, obs, vs[i].e);
         end
         next_cycle();
      end
   endtask

   task automatic test_zero_mask();
      vec_t vs [3] = '{
         '{1'b1, 24'hABCDEF, 3'b000, 1'b1, ex(0, 0, 1, 0, 2'd0, 8'h00)},
         '{1'b1, 24'h123456, 3'b000, 1'b1, ex(0, 0, 1, 0, 2'd0, 8'h00)},
         '{1'b0, 24'h000000, 3'b000, 1'b1, ex(0, 0, 1, 0, 2'd0, 8'h00)}};
      for (int i = 0; i < 3; i++) begin
         drive(vs[i]); #1;
         n_checks++;
         if (obs[13:11] !== vs[i].e[13:11]) begin
            n_fail++;
            $display("FAIL zero_mask cycle %0d: got %h expected %h", i, obs, vs[i].e);
         end
         next_cycle();
      end
   endtask

   // Stall on lane 1 while a different word is offered; it must not be taken.
   task automatic test_backpressure();
      vec_t vs [7] = '{
         '{1'b1, 24'h332211, 3'b111, 1'b1, ex(0, 0, 1, 0, 2'd0, 8'h00)},
         '{1'b0, 24'h000000, 3'b000, 1'b1, ex(1, 1, 0, 0, 2'd0, 8'h11)},
         '{1'b1, 24'hAAAAAA, 3'b111, 1'b0, ex(1, 1, 0, 0, 2'd1, 8'h22)},
         '{1'b1, 24'hAAAAAA, 3'b111, 1'b0, ex(1, 1, 0, 0, 2'd1, 8'h22)},
         '{1'b1, 24'hAAAAAA, 3'b111, 1'b1, ex(1, 1, 0, 0, 2'd1, 8'h22)},
         '{1'b0, 24'h000000, 3'b000, 1'b1, ex(1, 1, 1, 1, 2'd2, 8'h33)},
         '{1'b0, 24'h000000, 3'b000, 1'b1, ex(0, 0, 1, 0, 2'd0, 8'h00)}};
      for (int i = 0; i < 7; i++) begin
         drive(vs[i]); #1;
         n_checks++;
         if (vs[i].e[13] ? (obs !== vs[i].e) : (obs[13:11] !== vs[i].e[13:11])) begin
            n_fail++;
            $display("FAIL backpressure cycle %0d: got %h expected %h", i, obs, vs[i].e);
         end
         next_cycle();
      end
   endtask

   task automatic test_back_to_back();
      vec_t vs [7] = '{
         '{1'b1, 24'h030201, 3'b111, 1'b1, ex(0, 0, 1, 0, 2'd0, 8'h00)},
         '{1'b1, 24'h0C0B0A, 3'b011, 1'b1, ex(1, 1, 0, 0, 2'd0, 8'h01)},
         '{1'b1, 24'h0C0B0A, 3'b011, 1'b1, ex(1, 1, 0, 0, 2'd1, 8'h02)},
         '{1'b1, 24'h0C0B0A, 3'b011, 1'b1, ex(1, 1, 1, 1, 2'd2, 8'h03)},
         '{1'b0, 24'h000000, 3'b000, 1'b1, ex(1, 1, 0, 0, 2'd0, 8'h0A)},
         '{1'b0, 24'h000000, 3'b000, 1'b1, ex(1, 1, 1, 1, 2'd1, 8'h0B)},
         '{1'b0, 24'h000000, 3'b000, 1'b1, ex(0, 0, 1, 0, 2'd0, 8'h00)}};
      for (int i = 0; i < 7; i++) begin
         drive(vs[i]); #1;
         n_checks++;
         if (vs[i].e[13] ? (obs !== vs[i].e) : (obs[13:11] !== vs[i].e[13:11])) begin
            n_fail++;
            $display("FAIL back_to_back cycle %0d: got %h expected %h", i, obs, vs[i].e);
         end
         next_cycle();
      end
   endtask

   task automatic test_mid_word_reset();
      vec_t pre [2] = '{
         '{1'b1, 24'h332211, 3'b111, 1'b1, ex(0, 0, 1, 0, 2'd0, 8'h00)},
         '{1'b0, 24'h000000, 3'b000, 1'b1, ex(1, 1, 0, 0, 2'd0, 8'h11)}};
      vec_t post [3] = '{
         '{1'b1, 24'h005500, 3'b010, 1'b1, ex(0, 0, 1, 0, 2'd0, 8'h00)},
         '{1'b0, 24'h000000, 3'b000, 1'b1, ex(1, 1, 1, 1, 2'd1, 8'h55)},
         '{1'b0, 24'h000000, 3'b000, 1'b1, ex(0, 0, 1, 0, 2'd0, 8'h00)}};
      for (int i = 0; i < 2; i++) begin
         drive(pre[i]); #1;
         n_checks++;
         if (pre[i].e[13] ? (obs !== pre[i].e) : (obs[13:11] !== pre[i].e[13:11])) begin
            n_fail++;
            $display("FAIL reset_pre cycle %0d: got %h expected %h", i, obs, pre[i].e);
         end
         next_cycle();
      end
      // Lane 1 is now on the bus; reset must clear it without waiting for an edge.
      rst = 1'b1;
      #1;
      n_checks++;
      if (obs !== ex(0, 0, 1, 0, 2'd0, 8'h00)) begin
         n_fail++;
         $display("FAIL reset_async: got %h expected %h", obs, ex(0, 0, 1, 0, 2'd0, 8'h00));
      end
      next_cycle();
      rst = 1'b0;
      for (int i = 0; i < 3; i++) begin
         drive(post[i]); #1;
         n_checks++;
         if (post[i].e[13] ? (obs !== post[i].e) : (obs[13:11] !== post[i].e[13:11])) begin
            n_fail++;
            $display("FAIL reset_post cycle %0d: got %h expected %h", i, obs, post[i].e);
         end
         next_cycle();
      end
   endtask

   initial begin
      test_reset();
      test_full_mask();
      test_sparse_mask();
      test_zero_mask();
      test_backpressure();
      test_back_to_back();
      test_mid_word_reset();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
